// File: rtl/uwasic_pkg.sv
// rtl/uwasic_pkg.sv - shared register map and timing constants for the SPI PWM tile
package uwasic_pkg;
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_DUTY      = 7'd4;
    localparam logic [6:0] MAX_ADDR       = ADDR_DUTY;
    localparam int         CLK_DIV        = 13;
    localparam int         FRAME_BITS     = 16;
endpackage

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - mode-0 write-only SPI capture and five-register bank
module spi_peripheral
    import uwasic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        copi,
    input  logic        ncs,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty
);
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    logic [2:0]  sclk_q, sclk_d;
    logic [1:0]  copi_q, copi_d;
    logic [2:0]  ncs_q, ncs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        armed_q, armed_d;
    logic [15:0] en_out_q, en_out_d;
    logic [15:0] en_pwm_q, en_pwm_d;
    logic [7:0]  duty_q, duty_d;

    logic sclk_rise, ncs_fall, ncs_rise, frame_ok;

    always_comb begin
        sclk_d   = {sclk_q[1:0], sclk};
        copi_d   = {copi_q[0], copi};
        ncs_d    = {ncs_q[1:0], ncs};
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        armed_d  = armed_q;
        en_out_d = en_out_q;
        en_pwm_d = en_pwm_q;
        duty_d   = duty_q;

        sclk_rise = sclk_q[1] & ~sclk_q[2];
        ncs_fall  = ~ncs_q[1] & ncs_q[2];
        ncs_rise  = ncs_q[1] & ~ncs_q[2];
        frame_ok  = armed_q && (cnt_q == CNT_FULL) && shift_q[15]
                    && (shift_q[14:8] <= MAX_ADDR);

        // armed stays low after reset until a genuine nCS fall starts a frame
        if (ncs_fall) begin
            cnt_d   = 5'd0;
            shift_d = 16'h0000;
            armed_d = 1'b1;
        end else if (sclk_rise && !ncs_q[1] && armed_q) begin
            shift_d = {shift_q[14:0], copi_q[1]};
            if (cnt_q < CNT_SAT) begin
                cnt_d = cnt_q + 5'd1;
            end
        end

        if (ncs_rise) begin
            armed_d = 1'b0;
            if (frame_ok) begin
                case (shift_q[14:8])
                    ADDR_EN_OUT_LO: en_out_d[7:0]  = shift_q[7:0];
                    ADDR_EN_OUT_HI: en_out_d[15:8] = shift_q[7:0];
                    ADDR_EN_PWM_LO: en_pwm_d[7:0]  = shift_q[7:0];
                    ADDR_EN_PWM_HI: en_pwm_d[15:8] = shift_q[7:0];
                    ADDR_DUTY:      duty_d         = shift_q[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q   <= 3'b000;
            copi_q   <= 2'b00;
            ncs_q    <= 3'b000;
            cnt_q    <= 5'd0;
            shift_q  <= 16'h0000;
            armed_q  <= 1'b0;
            en_out_q <= 16'h0000;
            en_pwm_q <= 16'h0000;
            duty_q   <= 8'h00;
        end else begin
            sclk_q   <= sclk_d;
            copi_q   <= copi_d;
            ncs_q    <= ncs_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            armed_q  <= armed_d;
            en_out_q <= en_out_d;
            en_pwm_q <= en_pwm_d;
            duty_q   <= duty_d;
        end
    end

    assign en_out = en_out_q;
    assign en_pwm = en_pwm_q;
    assign duty   = duty_q;
endmodule

// File: rtl/uwasic_spi_pwm_top.sv
// rtl/uwasic_spi_pwm_top.sv - SPI-configured 16-pin output tile with shared 8-bit PWM
module uwasic_spi_pwm_top
    import uwasic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int                PRESC_W    = $clog2(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [15:0]        en_out, en_pwm;
    logic [7:0]         duty;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [15:0]        out_q, out_d;
    logic               pwm_sig;
    logic               unused_ok;

    spi_peripheral u_spi (
        .clk    (clk),
        .rst    (rst),
        .sclk   (ui_in[0]),
        .copi   (ui_in[1]),
        .ncs    (ui_in[2]),
        .en_out (en_out),
        .en_pwm (en_pwm),
        .duty   (duty)
    );

    always_comb begin
        presc_d   = presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (presc_q == PRESC_LAST) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end
        // full-scale duty must be solid high, which a plain compare cannot reach
        pwm_sig = (duty == 8'hFF) || (pwm_cnt_q < duty);
        out_d   = en_out & (~en_pwm | {16{pwm_sig}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= 8'h00;
            out_q     <= 16'h0000;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            out_q     <= out_d;
        end
    end

    assign uo_out    = out_q[7:0];
    assign uio_out   = out_q[15:8];
    assign uio_oe    = 8'hFF;
    assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};
endmodule

// File: tb/tb_uwasic_spi_pwm_top.sv
// tb/tb_uwasic_spi_pwm_top.sv - directed self-checking bench for uwasic_spi_pwm_top
module tb_uwasic_spi_pwm_top;
    logic       clk;
    logic       rst;
    logic       ena;
    logic       sclk, copi, ncs;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    assign ui_in = {5'b00000, ncs, copi, sclk};

    uwasic_spi_pwm_top dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic shift_bits(input logic [16:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            clocks(4);
            sclk = 1'b1;
            clocks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [16:0] v, input int n);
        ncs = 1'b0;
        clocks(4);
        shift_bits(v, n);
        clocks(4);
        ncs = 1'b1;
        clocks(10);
        @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        frame({1'b0, 1'b1, a, d}, 16);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uo_out[0]) ones++;
        end
    endtask

    task automatic measure(output int hi, output int lo, output logic ok);
        int n;
        n = 0; hi = 0; lo = 0;
        @(negedge clk);
        while (uo_out[0] && n < 5000) begin @(negedge clk); n++; end
        while (!uo_out[0] && n < 10000) begin @(negedge clk); n++; end
        while (uo_out[0] && n < 15000) begin hi++; @(negedge clk); n++; end
        while (!uo_out[0] && n < 20000) begin lo++; @(negedge clk); n++; end
        ok = (n < 20000);
    endtask

    initial begin
        int hi, lo, ones;
        logic ok;
        checks = 0; failures = 0;
        rst = 1'b1; ena = 1'b1; uio_in = 8'h00;
        sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        clocks(3);
        @(negedge clk);
        check("rst_uo", {24'h0, uo_out}, 32'h00);
        check("rst_uio", {24'h0, uio_out}, 32'h00);
        check("rst_oe", {24'h0, uio_oe}, 32'hFF);
        rst = 1'b0;
        clocks(5);

        // basic write to en_out low
        wr(7'h00, 8'hF0);
        check("t1_uo", {24'h0, uo_out}, 32'hF0);
        check("t1_uio", {24'h0, uio_out}, 32'h00);
        check("t1_oe", {24'h0, uio_oe}, 32'hFF);

        // bad address, first address past the map, and a read frame
        wr(7'h30, 8'hAA);
        check("t2_badaddr_uio", {24'h0, uio_out}, 32'h00);
        wr(7'h05, 8'hFF);
        check("t2_addr5_uio", {24'h0, uio_out}, 32'h00);
        frame({1'b0, 16'h00FF}, 16);
        check("t2_read_uo", {24'h0, uo_out}, 32'hF0);

        // short and long frames
        frame(17'h00081, 8);
        check("t3_short_uio", {24'h0, uio_out}, 32'h00);
        frame(17'h103FF, 17);
        check("t3_long_uio", {24'h0, uio_out}, 32'h00);
        wr(7'h01, 8'h0F);
        check("t3_valid_uio", {24'h0, uio_out}, 32'h0F);

        // pwm on bit 0 at half duty
        wr(7'h00, 8'h01);
        wr(7'h01, 8'h00);
        wr(7'h02, 8'h01);
        wr(7'h04, 8'h80);
        measure(hi, lo, ok);
        check("t4_edges_found", {31'h0, ok}, 32'h1);
        check("t4_high", hi, 32'd1664);
        check("t4_period", hi + lo, 32'd3328);

        wr(7'h04, 8'h00);
        count_ones(3400, ones);
        check("t5_duty00", ones, 32'd0);
        wr(7'h04, 8'hFF);
        count_ones(3400, ones);
        check("t5_dutyFF", ones, 32'd3400);
        wr(7'h04, 8'h00);
        wr(7'h02, 8'h00);
        count_ones(500, ones);
        check("t5_static_high", ones, 32'd500);
        wr(7'h00, 8'h00);
        count_ones(500, ones);
        check("t5_disabled", ones, 32'd0);

        // reset in the middle of a frame
        wr(7'h01, 8'hFF);
        check("t6_pre_uio", {24'h0, uio_out}, 32'hFF);
        ncs = 1'b0;
        clocks(4);
        shift_bits(17'h0813C, 5);
        #10 rst = 1'b1;
        #1;
        check("t6_async_uio", {24'h0, uio_out}, 32'h00);
        clocks(3);
        @(negedge clk);
        rst = 1'b0;
        shift_bits(17'h0813C, 11);
        clocks(4);
        ncs = 1'b1;
        clocks(10);
        @(negedge clk);
        check("t6_orphan_uio", {24'h0, uio_out}, 32'h00);
        wr(7'h01, 8'hA5);
        check("t6_post_uio", {24'h0, uio_out}, 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
